// File: rtl/piso_seq_feeder.sv
// -----------------------------------------------------------------------------
// piso_seq_feeder
//   Parallel-in / serial-out feeder for a bit-serial sequence detector.
//   Accepts WIDTH-bit words over a valid/ready handshake and emits exactly one
//   bit per clock on `a`. A one-word pending buffer lets a second word wait
//   while the current one shifts, so back-to-back words leave with no gap.
//   While nothing is shifting, `a` carries IDLE_BIT.
//
// Parameters
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT  value on `a` when no word is in flight
//
// Ports
//   clk        rising-edge clock
//   res        asynchronous active-low reset
//   din        parallel word
//   din_valid  din is valid this cycle
//   din_ready  block accepts din this cycle (combinational: res & !pvalid)
//   a          serial output bit
//   busy       a word is being shifted
//   last_bit   a carries the final bit of the current word
// -----------------------------------------------------------------------------
module piso_seq_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a,
  output logic             busy,
  output logic             last_bit
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_pbuf;
  logic [CW-1:0]    r_cnt;
  logic             r_pvalid;

  logic w_accept;
  logic w_last;
  logic w_out_bit;

  // Move the register one place toward whichever end drives `a`.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  // res is folded in so ready is low for the whole reset and rises the
  // moment reset is released.
  assign din_ready = res & ~r_pvalid;
  assign w_accept  = din_valid & din_ready;
  assign w_last    = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);
  assign w_out_bit = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

  // Outputs decode registered state only; nothing here looks at din/din_valid.
  assign busy     = (r_state == S_SHIFT);
  assign last_bit = w_last;
  assign a        = busy ? w_out_bit : IDLE_BIT;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_pbuf   <= '0;
      r_pvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sreg  <= din;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (!w_last) begin
            r_sreg <= shift_toward_out(r_sreg);
            r_cnt  <= r_cnt + CW'(1);
            if (w_accept) begin
              r_pbuf   <= din;
              r_pvalid <= 1'b1;
            end
          end else if (r_pvalid) begin
            // Pending word goes first; din_ready is low so no accept collides.
            r_sreg   <= r_pbuf;
            r_pvalid <= 1'b0;
            r_cnt    <= '0;
          end else if (w_accept) begin
            // Word offered on the last bit loads straight in, keeping a gapless.
            r_sreg <= din;
            r_cnt  <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_seq_feeder.sv
// -----------------------------------------------------------------------------
// tb_piso_seq_feeder
//   Two feeder instances (MSB-first and LSB-first) share clock and reset.
//   Each accepted word pushes its expected serial bits onto a per-instance
//   queue; every cycle the front of the queue is compared against `a`,
//   `busy` and `last_bit`, and an empty queue means the idle bit is expected.
// -----------------------------------------------------------------------------
module tb_piso_seq_feeder;

  localparam int W = 8;

  logic         clk;
  logic         res;

  logic [W-1:0] din_m, din_l;
  logic         vld_m, vld_l;
  logic         rdy_m, rdy_l;
  logic         a_m, a_l;
  logic         busy_m, busy_l;
  logic         last_m, last_l;

  int n_cmp = 0;
  int n_err = 0;

  // {last_bit, a} expected per cycle
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];

  piso_seq_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk       (clk),
    .res       (res),
    .din       (din_m),
    .din_valid (vld_m),
    .din_ready (rdy_m),
    .a         (a_m),
    .busy      (busy_m),
    .last_bit  (last_m)
  );

  piso_seq_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk       (clk),
    .res       (res),
    .din       (din_l),
    .din_valid (vld_l),
    .din_ready (rdy_l),
    .a         (a_l),
    .busy      (busy_l),
    .last_bit  (last_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---- scoreboard / monitor, MSB-first instance ----
  always @(negedge clk) begin
    logic [1:0] e;
    logic       exp_rdy;
    if (!res) begin
      q_m.delete();
      check("m_rst_a",    a_m,    0);
      check("m_rst_busy", busy_m, 0);
      check("m_rst_last", last_m, 0);
      check("m_rst_rdy",  rdy_m,  0);
    end else begin
      exp_rdy = (q_m.size() <= W);
      check("m_rdy", rdy_m, exp_rdy);
      if (q_m.size() > 0) begin
        e = q_m.pop_front();
        check("m_a",    a_m,    e[0]);
        check("m_busy", busy_m, 1);
        check("m_last", last_m, e[1]);
      end else begin
        check("m_idle_a",    a_m,    0);
        check("m_idle_busy", busy_m, 0);
        check("m_idle_last", last_m, 0);
      end
      if (vld_m && exp_rdy)
        for (int i = 0; i < W; i++) q_m.push_back({(i == W-1), din_m[W-1-i]});
    end
  end

  // ---- scoreboard / monitor, LSB-first instance ----
  always @(negedge clk) begin
    logic [1:0] e;
    logic       exp_rdy;
    if (!res) begin
      q_l.delete();
      check("l_rst_a",    a_l,    0);
      check("l_rst_busy", busy_l, 0);
      check("l_rst_rdy",  rdy_l,  0);
    end else begin
      exp_rdy = (q_l.size() <= W);
      check("l_rdy", rdy_l, exp_rdy);
      if (q_l.size() > 0) begin
        e = q_l.pop_front();
        check("l_a",    a_l,    e[0]);
        check("l_busy", busy_l, 1);
        check("l_last", last_l, e[1]);
      end else begin
        check("l_idle_a",    a_l,    0);
        check("l_idle_busy", busy_l, 0);
      end
      if (vld_l && exp_rdy)
        for (int i = 0; i < W; i++) q_l.push_back({(i == W-1), din_l[i]});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until the accepting edge; returns #1 after it.
  task automatic send(input bit lsb, input logic [W-1:0] w);
    int  n   = 0;
    bit  got = 0;
    logic r;
    if (lsb) begin din_l = w; vld_l = 1'b1; end
    else     begin din_m = w; vld_m = 1'b1; end
    while (!got && n < 40) begin
      @(negedge clk);
      r = lsb ? rdy_l : rdy_m;
      @(posedge clk);
      got = r;
      n++;
    end
    #1;
    if (lsb) vld_l = 1'b0; else vld_m = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  initial begin
    res   = 1'b0;
    din_m = 8'hFF; vld_m = 1'b1;
    din_l = 8'h00; vld_l = 1'b0;

    // Reset held with valid asserted: nothing may be accepted.
    cycles(2);
    check("rst_rdy_low", rdy_m, 0);
    vld_m = 1'b0;
    res   = 1'b1;
    #1;
    check("rdy_on_release", rdy_m, 1);
    cycles(3);

    // Single word, MSB-first.
    send(1'b0, 8'hB0);
    cycles(12);

    // Back-to-back: second word waits in the pending buffer.
    send(1'b0, 8'hB0);
    send(1'b0, 8'hBB);
    check("rdy_low_pending", rdy_m, 0);
    cycles(20);

    // Direct load offered only during the last-bit cycle.
    send(1'b0, 8'hB0);
    cycles(7);
    check("last_bit_cycle", last_m, 1);
    din_m = 8'h0B; vld_m = 1'b1;
    cycles(1);
    vld_m = 1'b0;
    cycles(12);

    // Reset mid-word with a pending word.
    send(1'b0, 8'hB0);
    send(1'b0, 8'hFF);
    cycles(1);
    res = 1'b0;
    #1;
    check("midrst_a",    a_m,    0);
    check("midrst_busy", busy_m, 0);
    cycles(2);
    res = 1'b1;
    cycles(1);
    send(1'b0, 8'hB0);
    cycles(12);

    // LSB-first instance.
    send(1'b1, 8'h0D);
    cycles(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
